// File: rtl/data_memory_banked_pkg.sv
// Shared definitions for the banked data memory: access size codes,
// FSM state encoding and small decode helpers.
package data_memory_banked_pkg;

  // Access size codes carried on the size input
  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HALF  = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam logic [1:0] SIZE_DWORD = 2'b11;

  // Controller states: post-reset clear sweep, then normal operation
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Number of bytes touched by an access of the given size
  function automatic logic [3:0] size_nbytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

  // Low address bits that must be zero for a naturally aligned access
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    logic [2:0] mask;
    case (size)
      SIZE_BYTE: mask = 3'b000;
      SIZE_HALF: mask = 3'b001;
      SIZE_WORD: mask = 3'b011;
      default:   mask = 3'b111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/data_memory_banked_load_align.sv
// Load alignment: pulls the addressed byte/half/word field out of a memory
// word, right-justifies it and sign- or zero-extends it to the full width.
module dmem_load_align
  import data_memory_banked_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] i_word,
  input  logic [LANE_W-1:0] i_lane,
  input  logic [1:0]        i_size,
  input  logic              i_sign_ext,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_shifted;
  logic              w_msb;

  assign w_shifted = i_word >> {i_lane, 3'b000};

  // Pick the top bit of the loaded field and fill everything above it
  always_comb begin
    w_msb  = 1'b0;
    o_data = '0;
    case (i_size)
      SIZE_BYTE: w_msb = w_shifted[7];
      SIZE_HALF: w_msb = w_shifted[15];
      SIZE_WORD: w_msb = w_shifted[31];
      default:   w_msb = w_shifted[DATA_W-1];
    endcase
    for (int i = 0; i < DATA_W; i++) begin
      if (i < (32'sd8 << i_size)) begin
        o_data[i] = w_shifted[i];
      end else begin
        o_data[i] = i_sign_ext & w_msb;
      end
    end
  end

endmodule

// File: rtl/data_memory_banked.sv
// Byte-addressed data memory with byte/half/word(/dword) loads and stores,
// registered reads, misalign/range error pulses and a post-reset clear sweep.
module data_memory_banked
  import data_memory_banked_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] read_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              err
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int IDX_W  = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  state_e            r_state;
  state_e            w_state_next;
  logic [IDX_W-1:0]  r_clr_ptr;
  logic [IDX_W-1:0]  w_clr_ptr_next;
  logic              r_busy;
  logic [DATA_W-1:0] r_read_data;
  logic              r_rd_valid;
  logic              r_err;

  logic [LANE_W-1:0] w_lane;
  logic [IDX_W-1:0]  w_index;
  logic              w_run;
  logic              w_upper_nz;
  logic              w_misaligned;
  logic              w_size_bad;
  logic              w_err_acc;
  logic              w_do_store;
  logic [NB-1:0]     w_be;
  logic [DATA_W-1:0] w_wdata_shift;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_load_data;

  assign w_lane  = address[LANE_W-1:0];
  assign w_index = address[LANE_W +: IDX_W];
  assign w_run   = (r_state == ST_RUN);

  // Any address bit above the word index means the access is past the array
  assign w_upper_nz   = ((address >> (LANE_W + IDX_W)) != '0);
  assign w_misaligned = ((address[2:0] & align_mask(size)) != 3'b000);
  assign w_size_bad   = (int'(size_nbytes(size)) > NB);
  assign w_err_acc    = w_upper_nz | w_misaligned | w_size_bad;
  assign w_do_store   = w_run & mem_wr & ~w_err_acc;

  assign w_wdata_shift = write_data << {w_lane, 3'b000};
  assign w_word        = r_mem[w_index];

  // Byte enables cover lanes lane .. lane+nbytes-1 of the addressed word
  always_comb begin
    w_be = '0;
    for (int b = 0; b < NB; b++) begin
      if ((b >= int'(w_lane)) && (b < int'(w_lane) + int'(size_nbytes(size)))) begin
        w_be[b] = 1'b1;
      end else begin
        w_be[b] = 1'b0;
      end
    end
  end

  // Storage: clear sweep writes zeros, otherwise byte-masked stores
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_ptr] <= '0;
    end else if (w_do_store) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) begin
          r_mem[w_index][8*b +: 8] <= w_wdata_shift[8*b +: 8];
        end
      end
    end
  end

  dmem_load_align #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_load_align (
    .i_word     (w_word),
    .i_lane     (w_lane),
    .i_size     (size),
    .i_sign_ext (sign_ext),
    .o_data     (w_load_data)
  );

  // Controller state, sweep pointer and busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= '0;
      r_busy    <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_clr_ptr <= w_clr_ptr_next;
      r_busy    <= (w_state_next == ST_CLEAR);
    end
  end

  // Next state: sweep every word once, then run until the next reset
  always_comb begin
    w_state_next   = r_state;
    w_clr_ptr_next = r_clr_ptr;
    case (r_state)
      ST_CLEAR: begin
        w_clr_ptr_next = r_clr_ptr + 1'b1;
        if (r_clr_ptr == IDX_W'(DEPTH - 1)) begin
          w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_CLEAR;
        end
      end
      ST_RUN: begin
        w_state_next   = ST_RUN;
        w_clr_ptr_next = r_clr_ptr;
      end
      default: begin
        w_state_next   = ST_CLEAR;
        w_clr_ptr_next = '0;
      end
    endcase
  end

  // Registered load result, valid and error pulses; read sees pre-store data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_read_data <= '0;
      r_rd_valid  <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_run & (mem_rd | mem_wr) & w_err_acc;
      if (w_run & mem_rd) begin
        r_rd_valid  <= 1'b1;
        r_read_data <= w_err_acc ? '0 : w_load_data;
      end else begin
        r_rd_valid  <= 1'b0;
        r_read_data <= r_read_data;
      end
    end
  end

  assign read_data = r_read_data;
  assign rd_valid  = r_rd_valid;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_data_memory_banked.sv
// Directed bench for data_memory_banked: a 32-bit instance for most scenarios
// and a 64-bit instance for doubleword round-trips.
module tb_data_memory_banked;

  logic        clk;
  logic        rst;

  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rd;
  logic        wr;
  logic [1:0]  sz;
  logic        sext;
  logic [31:0] rdata;
  logic        rvalid;
  logic        busy;
  logic        err;

  logic [31:0] addr64;
  logic [63:0] wdata64;
  logic        rd64;
  logic        wr64;
  logic [1:0]  sz64;
  logic        sext64;
  logic [63:0] rdata64;
  logic        rvalid64;
  logic        busy64;
  logic        err64;

  int n_vec;
  int n_bad;

  data_memory_banked #(.DATA_W(32), .DEPTH(256), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .address(addr), .write_data(wdata),
    .mem_rd(rd), .mem_wr(wr), .size(sz), .sign_ext(sext),
    .read_data(rdata), .rd_valid(rvalid), .busy(busy), .err(err)
  );

  data_memory_banked #(.DATA_W(64), .DEPTH(256), .ADDR_W(32)) dut64 (
    .clk(clk), .rst(rst), .address(addr64), .write_data(wdata64),
    .mem_rd(rd64), .mem_wr(wr64), .size(sz64), .sign_ext(sext64),
    .read_data(rdata64), .rd_valid(rvalid64), .busy(busy64), .err(err64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One request cycle on the 32-bit instance; returns 1 time unit after the edge
  task automatic req(input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] d, input logic [1:0] s, input logic se);
    rd = r; wr = w; addr = a; wdata = d; sz = s; sext = se;
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0; sz = 2'b00; sext = 1'b0;
  endtask

  task automatic req64(input logic r, input logic w, input logic [31:0] a,
                       input logic [63:0] d, input logic [1:0] s, input logic se);
    rd64 = r; wr64 = w; addr64 = a; wdata64 = d; sz64 = s; sext64 = se;
    @(posedge clk); #1;
    rd64 = 1'b0; wr64 = 1'b0; addr64 = 32'h0; wdata64 = 64'h0; sz64 = 2'b00; sext64 = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  // Count cycles with busy high starting at the reset release point
  task automatic count_busy(output int cnt);
    cnt = 0;
    if (busy) cnt++;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk); #1;
      if (busy) cnt++;
      else break;
    end
  endtask

  task automatic test_reset();
    int cnt;
    rst = 1'b1;
    #3;
    n_vec++;
    if (busy !== 1'b1 || rvalid !== 1'b0 || err !== 1'b0 || rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_state: busy=%b rd_valid=%b err=%b read_data=%h, want 1 0 0 00000000",
               busy, rvalid, err, rdata);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    count_busy(cnt);
    n_vec++;
    if (cnt !== 256) begin
      n_bad++;
      $display("FAIL busy_len: busy cycles=%0d, want 256", cnt);
    end
    req(1'b1, 1'b0, 32'h3FC, 32'h0, 2'b10, 1'b0);
    n_vec++;
    if (rvalid !== 1'b1 || rdata !== 32'h0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL lw_3fc: rd_valid=%b read_data=%h err=%b, want 1 00000000 0", rvalid, rdata, err);
    end
  endtask

  task automatic test_byte_loads();
    logic [31:0] exp_v [0:3];
    exp_v[0] = 32'h00000001; exp_v[1] = 32'h0000007F;
    exp_v[2] = 32'hFFFFFFFF; exp_v[3] = 32'hFFFFFF80;
    req(1'b0, 1'b1, 32'h10, 32'h80FF7F01, 2'b10, 1'b0);
    n_vec++;
    if (rvalid !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL sw_no_valid: rd_valid=%b err=%b, want 0 0", rvalid, err);
    end
    for (int i = 0; i < 4; i++) begin
      req(1'b1, 1'b0, 32'h10 + 32'(i), 32'h0, 2'b00, 1'b1);
      n_vec++;
      if (rvalid !== 1'b1 || rdata !== exp_v[i]) begin
        n_bad++;
        $display("FAIL lb_%0d: rd_valid=%b read_data=%h, want 1 %h", i, rvalid, rdata, exp_v[i]);
      end
      idle_cycle();
      n_vec++;
      if (rvalid !== 1'b0 || rdata !== exp_v[i]) begin
        n_bad++;
        $display("FAIL lb_hold_%0d: rd_valid=%b read_data=%h, want 0 %h", i, rvalid, rdata, exp_v[i]);
      end
    end
    req(1'b1, 1'b0, 32'h13, 32'h0, 2'b00, 1'b0);
    n_vec++;
    if (rvalid !== 1'b1 || rdata !== 32'h00000080) begin
      n_bad++;
      $display("FAIL lbu_13: rd_valid=%b read_data=%h, want 1 00000080", rvalid, rdata);
    end
    req(1'b1, 1'b0, 32'h12, 32'h0, 2'b01, 1'b1);
    n_vec++;
    if (rdata !== 32'hFFFF80FF) begin
      n_bad++;
      $display("FAIL lh_12: read_data=%h, want ffff80ff", rdata);
    end
  endtask

  task automatic test_partial_stores();
    req(1'b0, 1'b1, 32'h20, 32'hAAAAAAAA, 2'b10, 1'b0);
    req(1'b0, 1'b1, 32'h21, 32'hFFFFFF55, 2'b00, 1'b0);
    req(1'b0, 1'b1, 32'h22, 32'hFFFF1234, 2'b01, 1'b0);
    req(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
    n_vec++;
    if (rvalid !== 1'b1 || rdata !== 32'h123455AA) begin
      n_bad++;
      $display("FAIL merge_20: rd_valid=%b read_data=%h, want 1 123455aa", rvalid, rdata);
    end
  endtask

  task automatic test_errors();
    req(1'b1, 1'b0, 32'h02, 32'h0, 2'b10, 1'b0);
    n_vec++;
    if (err !== 1'b1 || rvalid !== 1'b1 || rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL lw_misalign: err=%b rd_valid=%b read_data=%h, want 1 1 00000000", err, rvalid, rdata);
    end
    req(1'b0, 1'b1, 32'h101, 32'h0000BEEF, 2'b01, 1'b0);
    n_vec++;
    if (err !== 1'b1 || rvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL sh_misalign: err=%b rd_valid=%b, want 1 0", err, rvalid);
    end
    idle_cycle();
    n_vec++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL err_pulse: err=%b, want 0", err);
    end
    req(1'b1, 1'b0, 32'h100, 32'h0, 2'b10, 1'b0);
    n_vec++;
    if (err !== 1'b0 || rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL mem_unchanged: err=%b read_data=%h, want 0 00000000", err, rdata);
    end
    req(1'b1, 1'b0, 32'h400, 32'h0, 2'b10, 1'b0);
    n_vec++;
    if (err !== 1'b1 || rvalid !== 1'b1 || rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL lw_range: err=%b rd_valid=%b read_data=%h, want 1 1 00000000", err, rvalid, rdata);
    end
    req(1'b1, 1'b0, 32'h10, 32'h0, 2'b11, 1'b0);
    n_vec++;
    if (err !== 1'b1 || rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL ld_on_32: err=%b read_data=%h, want 1 00000000", err, rdata);
    end
  endtask

  task automatic test_back_to_back();
    req(1'b0, 1'b1, 32'h30, 32'h11111111, 2'b10, 1'b0);
    req(1'b1, 1'b1, 32'h30, 32'h22222222, 2'b10, 1'b0);
    n_vec++;
    if (rvalid !== 1'b1 || rdata !== 32'h11111111) begin
      n_bad++;
      $display("FAIL rd_before_wr: rd_valid=%b read_data=%h, want 1 11111111", rvalid, rdata);
    end
    req(1'b1, 1'b0, 32'h30, 32'h0, 2'b10, 1'b0);
    n_vec++;
    if (rvalid !== 1'b1 || rdata !== 32'h22222222) begin
      n_bad++;
      $display("FAIL ld_after_st: rd_valid=%b read_data=%h, want 1 22222222", rvalid, rdata);
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    req(1'b1, 1'b0, 32'h30, 32'h0, 2'b10, 1'b0);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (rvalid !== 1'b0 || rdata !== 32'h0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_load: rd_valid=%b read_data=%h busy=%b, want 0 00000000 1", rvalid, rdata, busy);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    count_busy(cnt);
    n_vec++;
    if (cnt !== 256) begin
      n_bad++;
      $display("FAIL busy_len_mid: busy cycles=%0d, want 256", cnt);
    end
    req(1'b1, 1'b0, 32'h30, 32'h0, 2'b10, 1'b0);
    n_vec++;
    if (rvalid !== 1'b1 || rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL swept_30: rd_valid=%b read_data=%h, want 1 00000000", rvalid, rdata);
    end
  endtask

  task automatic test_dword64();
    n_vec++;
    if (busy64 !== 1'b0) begin
      n_bad++;
      $display("FAIL busy64: busy=%b, want 0", busy64);
    end
    req64(1'b0, 1'b1, 32'h8, 64'h8123456789ABCDEF, 2'b11, 1'b0);
    req64(1'b1, 1'b0, 32'h8, 64'h0, 2'b11, 1'b0);
    n_vec++;
    if (rvalid64 !== 1'b1 || err64 !== 1'b0 || rdata64 !== 64'h8123456789ABCDEF) begin
      n_bad++;
      $display("FAIL ld64: rd_valid=%b err=%b read_data=%h, want 1 0 8123456789abcdef",
               rvalid64, err64, rdata64);
    end
    req64(1'b1, 1'b0, 32'hC, 64'h0, 2'b10, 1'b1);
    n_vec++;
    if (rdata64 !== 64'hFFFFFFFF81234567) begin
      n_bad++;
      $display("FAIL lw64_hi: read_data=%h, want ffffffff81234567", rdata64);
    end
    req64(1'b1, 1'b0, 32'hC, 64'h0, 2'b11, 1'b0);
    n_vec++;
    if (err64 !== 1'b1 || rdata64 !== 64'h0) begin
      n_bad++;
      $display("FAIL ld64_misalign: err=%b read_data=%h, want 1 0", err64, rdata64);
    end
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    rd = 1'b0; wr = 1'b0; addr = 32'h0; wdata = 32'h0; sz = 2'b00; sext = 1'b0;
    rd64 = 1'b0; wr64 = 1'b0; addr64 = 32'h0; wdata64 = 64'h0; sz64 = 2'b00; sext64 = 1'b0;
    test_reset();
    test_byte_loads();
    test_partial_stores();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    test_dword64();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
